enum_code_tx: RTL and testbench

Serial transmitter for `test_enum` command codes (A=1, B=2, C=3) from the shared package `p`. Codes arrive on a valid/ready handshake, are buffered in a small FIFO, and are shifted out LSB-first on a single idle-high line with start, optional parity, and stop bits. It is the driving end of the enum-coded link whose receiving end decodes and checks the same codes in regression tests.

---
 rtl/enum_code_tx.sv | 198 +++++++++++++++++++
 tb/tb_enum_code_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/enum_code_tx.sv
`default_nettype none
// ============================================================================
// Module   : enum_code_tx
// Purpose  : Serial transmitter for 2-bit command codes (A=1, B=2, C=3).
//            Codes enter through a valid/ready handshake, are buffered in a
//            small FIFO and are shifted out LSB-first on an idle-high line as
//            start, D0, D1, [parity], stop. Each bit lasts DIV clock cycles.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset (aborts frame, flushes)
//            in_valid  - in_code is valid
//            in_ready  - FIFO not full (combinational)
//            in_code   - 2-bit code; 0 is illegal
//            tx        - registered serial line, idles high
//            busy      - high while a frame is being shifted
//            bad_code  - one-cycle pulse after code 0 is accepted
//            fifo_cnt  - current FIFO occupancy
// Config   : define ENUM_CODE_TX_PARITY_EN to insert an even-parity bit
//            (frames become 5*DIV cycles instead of 4*DIV).
// Revision : 1.0 - initial release
// ============================================================================
module enum_code_tx #(
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_code,
    output logic                     tx,
    output logic                     busy,
    output logic                     bad_code,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [7:0]      c_DIV_LAST  = 8'(DIV - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_D0    = 3'd2;
    localparam logic [2:0] c_S_D1    = 3'd3;
    localparam logic [2:0] c_S_STOP  = 3'd4;
`ifdef ENUM_CODE_TX_PARITY_EN
    localparam logic [2:0] c_S_PAR   = 3'd5;
`endif

    // FIFO storage and pointers
    logic [1:0]       r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr;
    logic [c_AW-1:0]  r_rd;
    logic [c_CW-1:0]  r_cnt;
    logic             r_bad;

    // Serializer state
    logic [2:0]       r_state;
    logic [7:0]       r_timer;
    logic [1:0]       r_data;
    logic             r_tx;
    logic             r_busy;

    logic             w_full;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic [1:0]       w_head;

    // Ready depends only on occupancy: a pop on the same edge never lets a
    // new code through while full.
    assign w_full   = (r_cnt == c_DEPTH_CNT);
    assign in_ready = !w_full;
    assign w_accept = in_valid && !w_full;
    assign w_push   = w_accept && (in_code != 2'd0);
    assign w_last   = (r_timer == c_DIV_LAST);
    assign w_head   = r_mem[r_rd];

    // Pop when idle, or on the final stop-bit cycle so the next start bit
    // follows with no idle gap.
    assign w_pop = (r_cnt != '0) &&
                   ((r_state == c_S_IDLE) || ((r_state == c_S_STOP) && w_last));

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign bad_code = r_bad;
    assign fifo_cnt = r_cnt;

    // Storage array carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= in_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_bad <= 1'b0;
        end else begin
            r_bad <= w_accept && (in_code == 2'd0);
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_timer <= 8'd0;
            r_data  <= 2'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            // Bit timer restarts on every state change; all changes out of
            // a bit state happen on its last cycle.
            if ((r_state == c_S_IDLE) || w_last) begin
                r_timer <= 8'd0;
            end else begin
                r_timer <= r_timer + 8'd1;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_S_START;
                        r_data  <= w_head;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_S_START: begin
                    if (w_last) begin
                        r_state <= c_S_D0;
                        r_tx    <= r_data[0];
                    end
                end
                c_S_D0: begin
                    if (w_last) begin
                        r_state <= c_S_D1;
                        r_tx    <= r_data[1];
                    end
                end
                c_S_D1: begin
                    if (w_last) begin
`ifdef ENUM_CODE_TX_PARITY_EN
                        r_state <= c_S_PAR;
                        r_tx    <= ^r_data;
`else
                        r_state <= c_S_STOP;
                        r_tx    <= 1'b1;
`endif
                    end
                end
`ifdef ENUM_CODE_TX_PARITY_EN
                c_S_PAR: begin
                    if (w_last) begin
                        r_state <= c_S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                c_S_STOP: begin
                    if (w_last) begin
                        if (w_pop) begin
                            r_state <= c_S_START;
                            r_data  <= w_head;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enum_code_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_enum_code_tx
// Purpose  : Self-checking bench for enum_code_tx. A queue-based reference
//            model (pending codes + list of expected line levels for the
//            frame in flight) predicts tx, busy, in_ready, fifo_cnt and
//            bad_code every cycle. Honors ENUM_CODE_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enum_code_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef ENUM_CODE_TX_PARITY_EN
    localparam int FRAME = 5 * DIV;
`else
    localparam int FRAME = 4 * DIV;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             in_code;
    logic                   tx;
    logic                   busy;
    logic                   bad_code;
    logic [$clog2(DEPTH):0] fifo_cnt;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    enum_code_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .tx       (tx),
        .busy     (busy),
        .bad_code (bad_code),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0] mq [$];   // codes waiting in the FIFO
    bit         mw [$];   // remaining line levels of current frame, one per cycle
    bit         m_bad;
    bit         m_acc;
    logic [1:0] m_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mw.delete();
            m_bad = 1'b0;
            m_acc = 1'b0;
        end else begin
            m_acc = in_valid && (mq.size() < DEPTH);
            m_bad = m_acc && (in_code == 2'd0);
            if ((mw.size() <= 1) && (mq.size() > 0)) begin
                m_c = mq.pop_front();
                mw.delete();
                repeat (DIV) mw.push_back(1'b0);
                repeat (DIV) mw.push_back(m_c[0]);
                repeat (DIV) mw.push_back(m_c[1]);
`ifdef ENUM_CODE_TX_PARITY_EN
                repeat (DIV) mw.push_back(m_c[0] ^ m_c[1]);
`endif
                repeat (DIV) mw.push_back(1'b1);
            end else if (mw.size() > 0) begin
                void'(mw.pop_front());
            end
            if (m_acc && (in_code != 2'd0)) begin
                mq.push_back(in_code);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx",       32'(tx),       32'((mw.size() > 0) ? mw[0] : 1'b1));
            check("busy",     32'(busy),     32'(mw.size() > 0));
            check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            check("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
            check("bad_code", 32'(bad_code), 32'(m_bad));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [1:0] c);
        int n = 0;
        in_valid = 1'b1;
        in_code  = c;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_acc && n < 200);
        if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((mw.size() != 0 || mq.size() != 0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(mw.size() == 0 && mq.size() == 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_code  = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",       32'(tx),       32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_bad",      32'(bad_code), 32'd0);
        check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single frame, code A
        push(2'd1);
        drain();

        // Burst A,B,C,C,B at full rate (fills FIFO, exercises full+pop)
        push(2'd1); push(2'd2); push(2'd3); push(2'd3); push(2'd2);
        drain();

        // Illegal code followed by C
        push(2'd0); push(2'd3);
        drain();

        // Full FIFO with valid held high while the serializer pops
        for (int i = 0; i < 8; i++) push(2'(i % 3 + 1));
        drain();

        // Randomized traffic including illegal codes
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_code  = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset in the middle of D1 with codes still queued
        push(2'd2); push(2'd2); push(2'd3);
        n = 0;
        while (mw.size() != FRAME - 2 * DIV - 1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("d1_reach_timeout", 32'(mw.size()), 32'(FRAME - 2 * DIV - 1));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx",       32'(tx),       32'd1);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(2'd2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
